// File: rtl/coms_pkg.sv
// rtl/coms_pkg.sv - constants and CRC shared by both ends of the motorboard status link
package coms_pkg;

  localparam logic [31:0] MAGICNUMBER  = 32'hDABBAD00;
  localparam int          FRAME_LENGTH = 8;
  localparam logic [15:0] CRC_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC_POLY     = 16'h8005;

  // Bit-serial CRC over 48 bits, data[47] shifted in first.
  function automatic logic [15:0] nextCRC16(input logic [47:0] data, input logic [15:0] crc);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 47; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = MAGICNUMBER[31:24];
      2'd1:    b = MAGICNUMBER[23:16];
      2'd2:    b = MAGICNUMBER[15:8];
      default: b = MAGICNUMBER[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/crc16_48.sv
// rtl/crc16_48.sv - combinational CRC-16 (x^16+x^15+x^2+1) over one 48-bit word
module crc16_48
  import coms_pkg::*;
(
  input  logic [47:0] data,
  output logic [15:0] crc
);

  assign crc = nextCRC16(data, CRC_INIT);

endmodule

// File: rtl/coms_frame_rx.sv
// rtl/coms_frame_rx.sv - status link frame decoder: magic hunt, collect, CRC check
module coms_frame_rx
  import coms_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2000
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [15:0] payload,
  output logic        frame_valid,
  output logic [7:0]  crc_err_cnt,
  output logic [7:0]  timeout_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {HUNT, COLLECT, CHECK} state_t;

  localparam int              IDLE_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]      LAST_IDX  = 3'(FRAME_LENGTH - 1);

  state_t            state, state_next;
  logic [1:0]        match_idx;
  logic [2:0]        byte_idx;
  logic [IDLE_W-1:0] idle_cnt;
  logic [7:0]        pay_hi, pay_lo, crc_hi, crc_lo;
  logic              chk_pass, chk_fail;
  logic [15:0]       crc_calc;
  logic              idle_active, timeout_hit, magic_hit, magic_done, hunting;

  crc16_48 u_crc (
    .data ({pay_lo, pay_hi, MAGICNUMBER[7:0], MAGICNUMBER[15:8],
            MAGICNUMBER[23:16], MAGICNUMBER[31:24]}),
    .crc  (crc_calc)
  );

  // CHECK also hunts, so a byte arriving right after a frame is never lost.
  assign hunting     = (state != COLLECT);
  assign magic_hit   = (rx_data == magic_byte(match_idx));
  assign magic_done  = rx_valid && hunting && magic_hit && (match_idx == 2'd3);
  assign idle_active = (match_idx != 2'd0) || (state == COLLECT);
  assign timeout_hit = idle_active && !rx_valid && (idle_cnt == IDLE_LAST);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout_hit) begin
      state_next = HUNT;
    end else begin
      case (state)
        HUNT:    if (magic_done) state_next = COLLECT;
        COLLECT: if (rx_valid && byte_idx == LAST_IDX) state_next = CHECK;
        default: state_next = HUNT;
      endcase
    end
  end

  always_comb begin
    busy = (state != HUNT) || (match_idx != 2'd0);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      match_idx   <= 2'd0;
      byte_idx    <= 3'd0;
      idle_cnt    <= '0;
      pay_hi      <= 8'h00;
      pay_lo      <= 8'h00;
      crc_hi      <= 8'h00;
      crc_lo      <= 8'h00;
      chk_pass    <= 1'b0;
      chk_fail    <= 1'b0;
      payload     <= 16'h0000;
      frame_valid <= 1'b0;
      crc_err_cnt <= 8'h00;
      timeout_cnt <= 8'h00;
    end else begin
      // match_idx wraps to 0 on the fourth magic byte as COLLECT takes over.
      if (timeout_hit) begin
        match_idx <= 2'd0;
      end else if (rx_valid && hunting) begin
        if (magic_hit) match_idx <= match_idx + 2'd1;
        else           match_idx <= (rx_data == MAGICNUMBER[31:24]) ? 2'd1 : 2'd0;
      end

      if (magic_done) begin
        byte_idx <= 3'd4;
      end else if (rx_valid && state == COLLECT) begin
        byte_idx <= byte_idx + 3'd1;
        case (byte_idx)
          3'd4:    pay_hi <= rx_data;
          3'd5:    pay_lo <= rx_data;
          3'd6:    crc_hi <= rx_data;
          default: crc_lo <= rx_data;
        endcase
      end

      if (rx_valid || !idle_active || timeout_hit) idle_cnt <= '0;
      else                                         idle_cnt <= idle_cnt + IDLE_W'(1);

      chk_pass    <= (state == CHECK) && (crc_calc == {crc_hi, crc_lo});
      chk_fail    <= (state == CHECK) && (crc_calc != {crc_hi, crc_lo});
      frame_valid <= chk_pass;
      if (chk_pass) payload <= {pay_hi, pay_lo};
      if (chk_fail && crc_err_cnt != 8'hFF) crc_err_cnt <= crc_err_cnt + 8'd1;
      if (timeout_hit && timeout_cnt != 8'hFF) timeout_cnt <= timeout_cnt + 8'd1;
    end
  end

endmodule

// File: doc/coms_frame_rx.md
# coms_frame_rx

Host-side frame decoder for the motorboard status link. It sits behind a `uart_rx` instance and consumes its byte strobe. It hunts for the magic word 0xDABBAD00, collects the 2-byte payload and 2-byte CRC, checks the CRC, and presents valid payloads with a one-cycle strobe. Bad or truncated frames are counted and discarded.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2000: consecutive idle cycles allowed between bytes of one frame before it is aborted.

Ports:
- `CLK` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `rx_data` in 8: byte from `uart_rx`.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `payload` out 16: last good payload, {byte4, byte5}; reset 0x0000.
- `frame_valid` out 1: one-cycle pulse when `payload` updates; reset 0.
- `crc_err_cnt` out 8: CRC failures, saturating at 0xFF; reset 0x00.
- `timeout_cnt` out 8: aborted frames, saturating at 0xFF; reset 0x00.
- `busy` out 1: high whenever state ≠ HUNT; reset 0.

## Operation
- Frame format, 8 bytes in wire order b0..b7: DA BB AD 00 P_hi P_lo C_hi C_lo.
- CRC definition:
  - Polynomial x^16+x^15+x^2+1, init 0xFFFF.
  - Computed in one step over the 48-bit word W = {b5,b4,b3,b2,b1,b0}, so b0 occupies W[7:0].
  - First serial bit is W[47].
  - Pass condition: C_hi == crc[15:8] and C_lo == crc[7:0].
- States:
  - HUNT: `match_idx` counts magic bytes matched (0..3).
    - On `rx_valid`, if the byte equals magic[match_idx], increment `match_idx`.
    - Otherwise set `match_idx` = 1 if the byte is 0xDA, else 0.
    - On the 4th match (0x00), go to COLLECT with byte index 4.
  - COLLECT: each `rx_valid` stores the byte at the current index and increments the index. The byte at index 7 moves to CHECK.
  - CHECK (exactly 1 cycle): compute the CRC, compare, register the result, return to HUNT.
    - Pass: load `payload`, pulse `frame_valid`.
    - Fail: `crc_err_cnt` += 1 (saturating).
- Timeout:
  - The idle counter runs only while `match_idx` > 0 or the state is COLLECT, and clears on every `rx_valid`.
  - When it reaches TIMEOUT_CYCLES without `rx_valid`: go to HUNT, `match_idx` = 0, `timeout_cnt` += 1 (saturating).
  - A timeout during partial magic (`match_idx` ≥ 1) also counts.
- A failed frame is not rescanned for an embedded magic word. This is an accepted limitation.
- `busy` = (state ≠ HUNT) OR (`match_idx` ≠ 0).

## Timing
- Latency: `frame_valid` is high during the cycle that begins 2 edges after the edge sampling b7's `rx_valid`. `payload` changes in that same cycle and holds until the next good frame.
- `rx_valid` during CHECK: the byte is processed by the HUNT rules in that same cycle. No byte is ever dropped.
- `rx_valid` in the cycle the idle counter would expire: the byte wins, no timeout.
- Back-to-back `rx_valid` on consecutive cycles is accepted.
- Counters at 0xFF stay at 0xFF. Only reset clears them.
- `rst_n` low at any time: immediate return to HUNT with `match_idx` = 0, all outputs at reset values, any partial frame discarded.
- `rst_n` deassertion is synchronised externally; no internal synchroniser.

## Structure
- Shared package `coms_pkg`: MAGICNUMBER (32'hDABBAD00), FRAME_LENGTH (8), CRC_INIT (16'hFFFF), function `nextCRC16` (48-bit data, x^16+x^15+x^2+1). The board-side transmitter uses the same package, so both ends share one CRC definition.
- State enum HUNT/COLLECT/CHECK stays local.
- One sub-module is natural: `crc16_48`, a purely combinational wrapper (48-bit in, 16-bit out) around `nextCRC16`, reusable by the transmitter.

## Test plan
- Good frame: bytes DA BB AD 00 12 34 + golden CRC (from `nextCRC16`) → one `frame_valid` pulse, `payload` = 0x1234, counters 0.
- Corrupted CRC: same frame with C_lo XOR 0x01 → no `frame_valid`, `payload` unchanged, `crc_err_cnt` = 1.
- Resync on junk: DA DA BB 55 DA BB AD 00 AB CD + golden CRC → `payload` = 0xABCD, exactly one pulse.
- Timeout (TIMEOUT_CYCLES = 50): DA BB AD 00 12, idle 50 cycles → `timeout_cnt` = 1, `busy` = 0. A following full good frame for 0x5678 then decodes.
- Stress: 256 bad-CRC frames back-to-back at one byte per cycle → `crc_err_cnt` = 0xFF. The next frame's first byte arrives in the CHECK cycle and its good frame still decodes.
- Reset mid-COLLECT: pull `rst_n` low after byte 5 → all outputs reset immediately. A fresh good frame after release decodes correctly.
